mem_access_ctrl: RTL and testbench

- MEM-stage controller for the 16-bit pipeline, directly upstream of the write-back data mux.
- Turns one load/store request per instruction into timed strobes for external SRAM or the UART register pair.
- Returns the loaded word as mem_data, plus a one-cycle done pulse the pipeline uses to release its stall.
- Bidirectional buses are split into in/out/output-enable; tristating is done at top level.

---
 rtl/mem_access_ctrl_pkg.sv | 12 +
 rtl/mem_access_ctrl_if.sv | 36 +++
 rtl/mem_access_ctrl_uart.sv | 33 +++
 rtl/mem_access_ctrl.sv | 82 ++++++++
 tb/tb_mem_access_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: op codes, default UART register addresses and FSM state encodings
package mem_access_ctrl_pkg;
    localparam int          MEM_OP_BUS     = 2;
    localparam logic [1:0]  MEM_OP_NOP     = 2'd0;
    localparam logic [1:0]  MEM_OP_READ    = 2'd1;
    localparam logic [1:0]  MEM_OP_WRITE   = 2'd2;
    localparam logic [15:0] UART_DATA_DEF  = 16'hBF00;
    localparam logic [15:0] UART_STAT_DEF  = 16'hBF01;
    typedef enum logic [3:0] {
        IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, U_STAT, U_RD, U_WR, U_WAIT, DONE
    } state_t;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: pipeline request/response, SRAM pins and UART pins of the MEM-stage controller
//   slave  : controller side (takes requests, drives strobes)
//   master : pipeline + memory side
interface mem_access_ctrl_if #(
    parameter int RAM_ADDR_W = 18
);
    logic                  mem_req;
    logic [1:0]            mem_op;
    logic [15:0]           mem_addr;
    logic [15:0]           mem_wdata;
    logic [15:0]           mem_data;
    logic                  mem_done;
    logic                  mem_busy;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [15:0]           ram_din;
    logic [15:0]           ram_dout;
    logic                  ram_dout_oe;
    logic                  ram_en_n;
    logic                  ram_oe_n;
    logic                  ram_we_n;
    logic                  uart_data_ready;
    logic                  uart_tbre;
    logic                  uart_tsre;
    logic                  uart_rdn;
    logic                  uart_wrn;
    modport slave (
        input  mem_req, mem_op, mem_addr, mem_wdata, ram_din, uart_data_ready, uart_tbre, uart_tsre,
        output mem_data, mem_done, mem_busy, ram_addr, ram_dout, ram_dout_oe, ram_en_n, ram_oe_n, ram_we_n,
               uart_rdn, uart_wrn
    );
    modport master (
        output mem_req, mem_op, mem_addr, mem_wdata, ram_din, uart_data_ready, uart_tbre, uart_tsre,
        input  mem_data, mem_done, mem_busy, ram_addr, ram_dout, ram_dout_oe, ram_en_n, ram_oe_n, ram_we_n,
               uart_rdn, uart_wrn
    );
endinterface

// File: rtl/mem_access_ctrl_uart.sv
// uart_port_ctrl: UART strobes, status word and U_RD/U_WR/U_WAIT sequencing
//   state_i            : current controller state
//   uart_*_i           : UART receive-ready and transmitter-empty flags
//   rx_byte_i          : UART byte on the low half of the shared data bus
//   uart_rdn_o/wrn_o   : UART strobes, active low
//   dout_oe_o          : drive the data bus during a UART write
//   stat_o, rx_word_o  : status word and zero-extended received byte
//   next_o             : successor of the UART states
module uart_port_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  state_t      state_i,
    input  logic        uart_data_ready_i,
    input  logic        uart_tbre_i,
    input  logic        uart_tsre_i,
    input  logic [7:0]  rx_byte_i,
    output logic        uart_rdn_o,
    output logic        uart_wrn_o,
    output logic        dout_oe_o,
    output logic [15:0] stat_o,
    output logic [15:0] rx_word_o,
    output state_t      next_o
);
    logic tx_empty;
    assign tx_empty   = uart_tbre_i & uart_tsre_i;
    assign stat_o     = {14'b0, uart_data_ready_i, tx_empty};
    assign rx_word_o  = {8'b0, rx_byte_i};
    assign uart_rdn_o = state_i != U_RD;
    assign uart_wrn_o = state_i != U_WR;
    // Data stays driven while waiting so the byte has hold time after the write strobe rises.
    assign dout_oe_o  = state_i inside {U_WR, U_WAIT};
    assign next_o     = state_i == U_WR ? U_WAIT : state_i == U_WAIT && !tx_empty ? U_WAIT : DONE;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer for external SRAM and the UART register pair
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mem_access_ctrl_if (request/response, SRAM pins, UART pins)
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int          RAM_ADDR_W     = 18,
    parameter logic [15:0] UART_DATA_ADDR = UART_DATA_DEF,
    parameter logic [15:0] UART_STAT_ADDR = UART_STAT_DEF
) (
    input logic              clk,
    input logic              rst,
    mem_access_ctrl_if.slave bus
);
    state_t                state_q, state_d, start_st, u_next;
    logic [15:0]           data_q, data_d, dout_q, u_stat, u_rx;
    logic [RAM_ADDR_W-1:0] addr_q;
    logic                  accept, is_rd, is_wr, u_rdn, u_wrn, u_oe;

    uart_port_ctrl u_uart (
        .state_i          (state_q),
        .uart_data_ready_i(bus.uart_data_ready),
        .uart_tbre_i      (bus.uart_tbre),
        .uart_tsre_i      (bus.uart_tsre),
        .rx_byte_i        (bus.ram_din[7:0]),
        .uart_rdn_o       (u_rdn),
        .uart_wrn_o       (u_wrn),
        .dout_oe_o        (u_oe),
        .stat_o           (u_stat),
        .rx_word_o        (u_rx),
        .next_o           (u_next)
    );

    always_comb begin
        is_rd    = bus.mem_op == MEM_OP_READ;
        is_wr    = bus.mem_op == MEM_OP_WRITE;
        accept   = state_q == IDLE && bus.mem_req && (is_rd || is_wr);
        // Routing is decided on the accept edge, so later address changes cannot retarget the access.
        start_st = bus.mem_addr == UART_DATA_ADDR ? (is_wr ? U_WR : U_RD) :
                   bus.mem_addr == UART_STAT_ADDR ? U_STAT : is_wr ? WR_SETUP : RD;
        state_d  = state_q;
        case (state_q)
            IDLE:                  state_d = accept ? start_st : IDLE;
            RD:                    state_d = DONE;
            WR_SETUP:              state_d = WR_PULSE;
            WR_PULSE:              state_d = WR_HOLD;
            U_RD, U_WR, U_WAIT:    state_d = u_next;
            default:               state_d = IDLE;
        endcase
        // Status is captured on the accept edge so it is valid during its single done cycle.
        data_d = state_q == RD ? bus.ram_din : state_q == U_RD ? u_rx :
                 accept && is_rd && start_st == U_STAT ? u_stat : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            dout_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            if (accept) begin
                addr_q <= RAM_ADDR_W'(bus.mem_addr);
                dout_q <= bus.mem_wdata;
            end
        end
    end

    assign bus.mem_data    = data_q;
    assign bus.mem_done    = state_q inside {WR_HOLD, U_STAT, DONE};
    assign bus.mem_busy    = state_q != IDLE;
    assign bus.ram_addr    = addr_q;
    assign bus.ram_dout    = dout_q;
    assign bus.ram_dout_oe = state_q inside {WR_SETUP, WR_PULSE, WR_HOLD} || u_oe;
    assign bus.ram_en_n    = !(state_q inside {RD, WR_SETUP, WR_PULSE, WR_HOLD});
    assign bus.ram_oe_n    = state_q != RD;
    assign bus.ram_we_n    = state_q != WR_PULSE;
    assign bus.uart_rdn    = u_rdn;
    assign bus.uart_wrn    = u_wrn;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vector table plus multi-cycle sequences for mem_access_ctrl
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] din;
        logic        dr;
        logic        tbre;
        logic        tsre;
        logic [15:0] exp_data;
        int          exp_lat;
        int          exp_we;
        int          exp_oe;
        int          exp_rd;
        int          exp_wr;
        bit          sram;
    } vec_t;

    logic        clk = 0;
    logic        rst = 1;
    logic [15:0] ext_din = 16'h0;
    logic [15:0] sram [0:255];
    int          checks = 0;
    int          failures = 0;
    vec_t        vecs [12];

    mem_access_ctrl_if #(.RAM_ADDR_W(18)) bus ();

    mem_access_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.ram_din = (!bus.ram_en_n && !bus.ram_oe_n) ? sram[bus.ram_addr[7:0]] : ext_din;

    always @(posedge clk)
        if (!bus.ram_en_n && !bus.ram_we_n) sram[bus.ram_addr[7:0]] <= bus.ram_dout;

    always @(negedge clk)
        if (!rst) begin
            checks++;
            if ((bus.ram_dout_oe && !bus.ram_oe_n) || (!bus.uart_rdn && !bus.ram_oe_n) ||
                (!bus.ram_we_n && !bus.uart_wrn)) begin
                failures++;
                $display("FAIL invariant: oe=%b oe_n=%b rdn=%b we_n=%b wrn=%b", bus.ram_dout_oe,
                         bus.ram_oe_n, bus.uart_rdn, bus.ram_we_n, bus.uart_wrn);
            end
        end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata);
        bus.mem_req   = 1;
        bus.mem_op    = op;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int lat = 0, we_c = 0, oe_c = 0, rd_c = 0, wr_c = 0, busy_c = 0;
        logic [17:0] a = '0;
        @(negedge clk);
        drive(v.op, v.addr, v.wdata);
        ext_din = v.din;
        bus.uart_data_ready = v.dr;
        bus.uart_tbre = v.tbre;
        bus.uart_tsre = v.tsre;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) a = bus.ram_addr;
            we_c   += int'(!bus.ram_we_n);
            oe_c   += int'(!bus.ram_oe_n);
            rd_c   += int'(!bus.uart_rdn);
            wr_c   += int'(!bus.uart_wrn);
            busy_c += int'(bus.mem_busy);
            if (bus.mem_done) lat = k;
        end
        bus.mem_req = 0;
        bus.mem_op  = MEM_OP_NOP;
        chk($sformatf("v%0d_latency", i), lat, v.exp_lat);
        chk($sformatf("v%0d_mem_data", i), bus.mem_data, v.exp_data);
        chk($sformatf("v%0d_we_cycles", i), we_c, v.exp_we);
        chk($sformatf("v%0d_oe_cycles", i), oe_c, v.exp_oe);
        chk($sformatf("v%0d_rdn_cycles", i), rd_c, v.exp_rd);
        chk($sformatf("v%0d_wrn_cycles", i), wr_c, v.exp_wr);
        chk($sformatf("v%0d_busy_cycles", i), busy_c, v.exp_lat);
        if (v.sram) chk($sformatf("v%0d_ram_addr", i), a, {2'b0, v.addr});
        @(negedge clk);
        chk($sformatf("v%0d_done_one_cycle", i), bus.mem_done, 0);
    endtask

    initial begin
        int  lat;
        bit  hit;
        for (int i = 0; i < 256; i++) sram[i] = 16'h0;
        bus.mem_req = 0;
        bus.mem_op = MEM_OP_NOP;
        bus.mem_addr = 16'h0;
        bus.mem_wdata = 16'h0;
        bus.uart_data_ready = 0;
        bus.uart_tbre = 1;
        bus.uart_tsre = 1;
        //          op            addr      wdata     din       dr tb ts exp_data lat we oe rd wr sram
        vecs[0]  = '{MEM_OP_WRITE, 16'h4000, 16'hA5C3, 16'h0000, 0, 1, 1, 16'h0000, 3, 1, 0, 0, 0, 1};
        vecs[1]  = '{MEM_OP_READ,  16'h4000, 16'h0000, 16'h0000, 0, 1, 1, 16'hA5C3, 2, 0, 1, 0, 0, 1};
        vecs[2]  = '{MEM_OP_WRITE, 16'h0010, 16'h1234, 16'h0000, 0, 1, 1, 16'hA5C3, 3, 1, 0, 0, 0, 1};
        vecs[3]  = '{MEM_OP_READ,  16'h0010, 16'h0000, 16'h0000, 0, 1, 1, 16'h1234, 2, 0, 1, 0, 0, 1};
        vecs[4]  = '{MEM_OP_WRITE, 16'hFFFF, 16'hBEEF, 16'h0000, 0, 1, 1, 16'h1234, 3, 1, 0, 0, 0, 1};
        vecs[5]  = '{MEM_OP_READ,  16'hFFFF, 16'h0000, 16'h0000, 0, 1, 1, 16'hBEEF, 2, 0, 1, 0, 0, 1};
        vecs[6]  = '{MEM_OP_WRITE, 16'hBF02, 16'h1111, 16'h0000, 0, 1, 1, 16'hBEEF, 3, 1, 0, 0, 0, 1};
        vecs[7]  = '{MEM_OP_READ,  16'hBF02, 16'h0000, 16'h0000, 0, 1, 1, 16'h1111, 2, 0, 1, 0, 0, 1};
        vecs[8]  = '{MEM_OP_READ,  16'hBF01, 16'h0000, 16'h0000, 1, 1, 0, 16'h0002, 1, 0, 0, 0, 0, 0};
        vecs[9]  = '{MEM_OP_READ,  16'hBF01, 16'h0000, 16'h0000, 0, 1, 1, 16'h0001, 1, 0, 0, 0, 0, 0};
        vecs[10] = '{MEM_OP_READ,  16'hBF00, 16'h0000, 16'hFF7E, 0, 1, 1, 16'h007E, 2, 0, 0, 1, 0, 0};
        vecs[11] = '{MEM_OP_WRITE, 16'hBF00, 16'h0041, 16'h0000, 0, 1, 1, 16'h007E, 3, 0, 0, 0, 1, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_data", bus.mem_data, 16'h0);
        chk("reset_done_busy", {bus.mem_done, bus.mem_busy}, 2'b00);
        chk("reset_strobes", {bus.ram_en_n, bus.ram_oe_n, bus.ram_we_n, bus.uart_rdn, bus.uart_wrn}, 5'b11111);
        chk("reset_dout_oe", bus.ram_dout_oe, 1'b0);
        chk("reset_ram_addr", bus.ram_addr, 18'h0);
        chk("reset_ram_dout", bus.ram_dout, 16'h0);
        rst = 0;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            drive(n == 0 ? MEM_OP_NOP : 2'd3, 16'h4000, 16'h7777);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk($sformatf("nop%0d_idle", n),
                    {bus.ram_en_n, bus.ram_oe_n, bus.ram_we_n, bus.uart_rdn, bus.uart_wrn, bus.mem_done, bus.mem_busy},
                    7'b1111100);
            end
        end
        bus.mem_req = 0;

        @(negedge clk);
        drive(MEM_OP_READ, 16'h4000, 16'h0);
        @(posedge clk);
        #1;
        drive(MEM_OP_WRITE, 16'h1234, 16'h9999);
        @(negedge clk);
        chk("retarget_addr_rd", {bus.ram_addr, bus.ram_oe_n}, {18'h04000, 1'b0});
        @(negedge clk);
        chk("retarget_done", {bus.mem_done, bus.ram_addr}, {1'b1, 18'h04000});
        chk("retarget_data", bus.mem_data, 16'hA5C3);
        bus.mem_req = 0;
        bus.mem_op = MEM_OP_NOP;

        @(negedge clk);
        drive(MEM_OP_READ, 16'h0010, 16'h0);
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.mem_done) lat = k;
        end
        chk("b2b_first_latency", lat, 2);
        @(negedge clk);
        chk("b2b_idle_gap", {bus.mem_busy, bus.mem_done}, 2'b00);
        @(negedge clk);
        chk("b2b_second_accept", {bus.mem_busy, bus.ram_oe_n}, 2'b10);
        @(negedge clk);
        chk("b2b_second_done", {bus.mem_done, bus.mem_data}, {1'b1, 16'h1234});
        bus.mem_req = 0;
        bus.mem_op = MEM_OP_NOP;

        @(negedge clk);
        drive(MEM_OP_WRITE, 16'hBF00, 16'h0041);
        bus.uart_tbre = 1;
        bus.uart_tsre = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("slow_tx_wait%0d", k), {bus.mem_busy, bus.mem_done}, 2'b10);
        end
        bus.uart_tsre = 1;
        @(negedge clk);
        chk("slow_tx_done", {bus.mem_busy, bus.mem_done}, 2'b11);
        chk("slow_tx_data_kept", bus.mem_data, 16'h1234);
        bus.mem_req = 0;
        bus.mem_op = MEM_OP_NOP;

        @(negedge clk);
        drive(MEM_OP_WRITE, 16'h0020, 16'h5555);
        hit = 0;
        for (int k = 0; k < 8 && !hit; k++) begin
            @(negedge clk);
            if (!bus.ram_we_n) hit = 1;
        end
        chk("rst_mid_we_seen", hit, 1'b1);
        rst = 1;
        bus.mem_req = 0;
        @(posedge clk);
        #1;
        chk("rst_mid_outputs", {bus.ram_we_n, bus.ram_dout_oe, bus.mem_busy, bus.mem_done}, 4'b1000);
        chk("rst_mid_mem_data", bus.mem_data, 16'h0);
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_no_done%0d", k), {bus.mem_busy, bus.mem_done}, 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
